// File: rtl/bmsce_tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer: FSM encoding,
// uio pin bit positions and an index-width helper.
package bmsce_tdm_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int UPD_LSB  = 0;
    localparam int LOCK_BIT = 4;
    localparam int ERR_BIT  = 5;
    localparam int SLOT_LSB = 6;

    // Width of a counter/index covering 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bmsce_tdm_deser.sv
// Bit/slot counters and MSB-first shift register for the TDM receive path.
// Presents each completed slot word combinationally alongside word_done.
module bmsce_tdm_deser
    import bmsce_tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SLOT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      take,
    input  logic                      restart,
    input  logic                      clear,
    input  logic                      sdata,
    output logic [SLOT_W-1:0]         word,
    output logic [idx_w(NUM_CH)-1:0]  word_slot,
    output logic                      word_done,
    output logic [idx_w(NUM_CH)-1:0]  slot,
    output logic                      frame_start
);

    localparam int BIT_W  = idx_w(SLOT_W);
    localparam int SLOT_IW = idx_w(NUM_CH);

    logic [BIT_W-1:0]   bit_cnt;
    logic [SLOT_IW-1:0] slot_cnt;
    logic [SLOT_W-1:0]  shreg;

    logic [BIT_W-1:0]   eff_bit;
    logic [SLOT_IW-1:0] eff_slot;
    logic [SLOT_W-1:0]  eff_sh;
    logic               last_bit;
    logic               last_slot;

    // A restart treats the current bit as bit 0 of slot 0, dropping any partial slot.
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        eff_bit   = restart ? '0 : bit_cnt;
        eff_slot  = restart ? '0 : slot_cnt;
        eff_sh    = restart ? '0 : shreg;
        last_bit  = (eff_bit == BIT_W'(SLOT_W - 1));
        last_slot = (eff_slot == SLOT_IW'(NUM_CH - 1));
    end

    assign word        = (eff_sh << 1) | SLOT_W'(sdata);
    assign word_slot   = eff_slot;
    assign word_done   = take & last_bit;
    assign slot        = slot_cnt;
    assign frame_start = (bit_cnt == '0) && (slot_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            bit_cnt  <= '0;
            slot_cnt <= '0;
            shreg    <= '0;
        end else if (take) begin
            shreg <= word;
            if (last_bit) begin
                bit_cnt  <= '0;
                slot_cnt <= last_slot ? '0 : eff_slot + SLOT_IW'(1);
            end else begin
                bit_cnt  <= eff_bit + BIT_W'(1);
                slot_cnt <= eff_slot;
            end
        end
    end

endmodule

// File: rtl/bmsce_tdm_demux.sv
// 1-to-N TDM demultiplexer in the TinyTapeout wrapper: frame-sync FSM,
// sticky error flag, per-channel hold bank and registered channel view.
module bmsce_tdm_demux
    import bmsce_tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SLOT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int SLOT_IW = idx_w(NUM_CH);

    logic       fs;
    logic       sdata;
    logic       bit_en;
    logic [1:0] view_sel;
    logic       err_clr;

    assign fs       = ui_in[0];
    assign sdata    = ui_in[1];
    assign bit_en   = ui_in[2];
    assign view_sel = ui_in[4:3];
    assign err_clr  = ui_in[5];

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:6], uio_in};

    state_t             state;
    logic               take;
    logic               restart;
    logic               clear;
    logic               err_set;
    logic               frame_start;
    logic               word_done;
    logic [SLOT_W-1:0]  word;
    logic [SLOT_IW-1:0] word_slot;
    logic [SLOT_IW-1:0] cur_slot;

    logic [SLOT_W-1:0]  hold [NUM_CH];
    logic [NUM_CH-1:0]  upd;
    logic               frame_err;
    logic [7:0]         view_q;
    logic               lock;

    bmsce_tdm_deser #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .take        (take),
        .restart     (restart),
        .clear       (clear),
        .sdata       (sdata),
        .word        (word),
        .word_slot   (word_slot),
        .word_done   (word_done),
        .slot        (cur_slot),
        .frame_start (frame_start)
    );

    // Frame bit 0 must carry fs, and fs anywhere else is an error: both mismatches flag.
    always_comb begin
        take    = 1'b0;
        restart = 1'b0;
        clear   = 1'b0;
        err_set = 1'b0;
        if (bit_en) begin
            if (state == HUNT) begin
                take    = fs;
                restart = fs;
            end else if (frame_start) begin
                take    = fs;
                clear   = ~fs;
                err_set = ~fs;
            end else begin
                take    = 1'b1;
                restart = fs;
                err_set = fs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            upd       <= '0;
            frame_err <= 1'b0;
            view_q    <= '0;
            // NOTE: the hold bank is small and must read zero after reset, so it is reset like any register.
            for (int c = 0; c < NUM_CH; c++) begin
                hold[c] <= '0;
            end
        end else begin
            upd <= '0;
            if (word_done) begin
                hold[word_slot] <= word;
                upd[word_slot]  <= 1'b1;
            end

            // A new error overrides a simultaneous clear.
            frame_err <= err_set | (frame_err & ~err_clr);

            view_q <= (int'(view_sel) < NUM_CH) ? 8'(hold[view_sel[SLOT_IW-1:0]]) : 8'h00;

            if (bit_en) begin
                case (state)
                    HUNT: begin
                        if (fs) state <= SYNC;
                    end
                    SYNC, LOCKED: begin
                        if (frame_start)
                            state <= fs ? LOCKED : HUNT;
                        else if (fs)
                            state <= SYNC;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign lock   = (state == LOCKED);
    assign uo_out = view_q;
    assign uio_oe = 8'hFF;

    always_comb begin
        uio_out                   = '0;
        uio_out[UPD_LSB +: 4]     = 4'(upd);
        uio_out[LOCK_BIT]         = lock;
        uio_out[ERR_BIT]          = frame_err;
        uio_out[SLOT_LSB +: 2]    = 2'(cur_slot);
    end

endmodule

// File: tb/tb_bmsce_tdm_demux.sv
// Directed bench for bmsce_tdm_demux (NUM_CH=4, SLOT_W=8) with hand-computed
// expectations for framing, deserialisation, errors and reset.
module tb_bmsce_tdm_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       fs;
    logic       sdata;
    logic       bit_en;
    logic [1:0] view_sel;
    logic       err_clr;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int gap;
    int n_checks;
    int n_err;

    assign ui_in = {2'b00, err_clr, view_sel, bit_en, sdata, fs};

    always #5 clk = ~clk;

    bmsce_tdm_demux #(
        .NUM_CH (4),
        .SLOT_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One qualified bit, then `gap` idle cycles with a stray fs that must be ignored.
    task automatic send_bit(input logic f, input logic d, input logic [3:0] exp_upd);
        fs     = f;
        sdata  = d;
        bit_en = 1'b1;
        tick();
        check("upd", {28'd0, uio_out[3:0]}, {28'd0, exp_upd});
        for (int g = 0; g < gap; g++) begin
            fs     = 1'b1;
            sdata  = ~d;
            bit_en = 1'b0;
            tick();
            check("gap_upd", {28'd0, uio_out[3:0]}, 32'd0);
        end
        fs     = 1'b0;
        bit_en = 1'b0;
    endtask

    task automatic send_part(input logic [7:0] w, input int lo, input int hi,
                             input logic f0, input logic [3:0] exp7);
        for (int i = lo; i <= hi; i++) begin
            send_bit(f0 && (i == lo), w[7-i], (i == 7) ? exp7 : 4'b0000);
        end
    endtask

    task automatic send_frame(input logic [31:0] fr);
        for (int c = 0; c < 4; c++) begin
            send_part(fr[31-8*c -: 8], 0, 7, c == 0, 4'(1 << c));
        end
    endtask

    task automatic check_views(input logic [31:0] fr);
        bit_en = 1'b0;
        for (int v = 0; v < 4; v++) begin
            view_sel = 2'(v);
            tick();
            check("view", {24'd0, uo_out}, {24'd0, fr[31-8*v -: 8]});
        end
    endtask

    function automatic logic [31:0] flag(input int b);
        return {31'd0, uio_out[b]};
    endfunction

    initial begin
        n_checks = 0;
        n_err    = 0;
        gap      = 0;
        ena      = 1'b1;
        uio_in   = 8'h00;
        fs       = 1'b0;
        sdata    = 1'b0;
        bit_en   = 1'b0;
        view_sel = 2'd0;
        err_clr  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_uo", {24'd0, uo_out}, 32'd0);
        check("rst_uio", {24'd0, uio_out}, 32'd0);
        check("uio_oe", {24'd0, uio_oe}, 32'hFF);
        rst_n = 1'b1;
        tick();

        // 1: first frame, two-stage latency to uo_out, lock on second fs
        send_part(8'hA5, 0, 7, 1'b1, 4'b0001);
        check("lat_hold", {24'd0, uo_out}, 32'h00);
        send_part(8'h3C, 0, 0, 1'b0, 4'b0000);
        check("lat_view", {24'd0, uo_out}, 32'hA5);
        check("slot_after0", {30'd0, uio_out[7:6]}, 32'd1);
        send_part(8'h3C, 1, 7, 1'b0, 4'b0010);
        send_part(8'hFF, 0, 7, 1'b0, 4'b0100);
        send_part(8'h01, 0, 7, 1'b0, 4'b1000);
        check("sync_nolock", flag(4), 32'd0);
        check("slot_wrap", {30'd0, uio_out[7:6]}, 32'd0);
        send_frame(32'hA53CFF01);
        check("lock_2nd_fs", flag(4), 32'd1);
        check("no_err1", flag(5), 32'd0);
        check_views(32'hA53CFF01);

        // 2: same frame with bit_en every third cycle after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_view0", {24'd0, uo_out}, 32'd0);
        gap = 2;
        send_frame(32'hA53CFF01);
        send_frame(32'hA53CFF01);
        gap = 0;
        check("lock_gap", flag(4), 32'd1);
        check_views(32'hA53CFF01);

        // 3: early fs at frame bit 13 while locked
        view_sel = 2'd1;
        send_part(8'h11, 0, 7, 1'b1, 4'b0001);
        send_part(8'h22, 0, 4, 1'b0, 4'b0000);
        send_part(8'h55, 0, 0, 1'b1, 4'b0000);
        check("early_err", flag(5), 32'd1);
        check("early_unlock", flag(4), 32'd0);
        check("early_slot", {30'd0, uio_out[7:6]}, 32'd0);
        check("early_hold1", {24'd0, uo_out}, 32'h3C);
        send_part(8'h55, 1, 7, 1'b0, 4'b0001);
        check("early_hold1b", {24'd0, uo_out}, 32'h3C);
        send_part(8'h66, 0, 7, 1'b0, 4'b0010);
        send_part(8'h77, 0, 7, 1'b0, 4'b0100);
        send_part(8'h88, 0, 7, 1'b0, 4'b1000);
        check("realign_nolock", flag(4), 32'd0);
        check_views(32'h55667788);
        send_frame(32'hAABBCCDD);
        check("relock", flag(4), 32'd1);
        check("err_sticky", flag(5), 32'd1);
        check_views(32'hAABBCCDD);

        // 4: missing fs at a frame start
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", flag(5), 32'd0);
        send_part(8'h12, 0, 0, 1'b0, 4'b0000);
        check("miss_err", flag(5), 32'd1);
        check("miss_unlock", flag(4), 32'd0);
        check("miss_slot", {30'd0, uio_out[7:6]}, 32'd0);
        send_part(8'h34, 0, 7, 1'b0, 4'b0000);
        send_part(8'h56, 0, 7, 1'b0, 4'b0000);
        check_views(32'hAABBCCDD);
        send_frame(32'h01020304);
        check("recover_nolock", flag(4), 32'd0);
        check_views(32'h01020304);
        send_frame(32'h05060708);
        check("recover_lock", flag(4), 32'd1);

        // 5: err_clr coinciding with a new error
        err_clr = 1'b1;
        tick();
        check("clr_before", flag(5), 32'd0);
        send_part(8'h00, 0, 0, 1'b0, 4'b0000);
        err_clr = 1'b0;
        check("err_wins", flag(5), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_alone", flag(5), 32'd0);

        // 6: reset pulse at bit 20 of a locked frame
        send_frame(32'hF00F5AC3);
        send_part(8'h11, 0, 7, 1'b1, 4'b0001);
        check("pre_rst_lock", flag(4), 32'd1);
        send_part(8'h22, 0, 7, 1'b0, 4'b0010);
        send_part(8'h33, 0, 3, 1'b0, 4'b0000);
        view_sel = 2'd0;
        rst_n    = 1'b0;
        fs       = 1'b0;
        sdata    = 1'b1;
        bit_en   = 1'b1;
        tick();
        rst_n  = 1'b1;
        bit_en = 1'b0;
        check("midrst_uo", {24'd0, uo_out}, 32'd0);
        check("midrst_uio", {24'd0, uio_out}, 32'd0);
        check_views(32'h00000000);
        send_frame(32'h9ABCDEF1);
        check_views(32'h9ABCDEF1);
        send_part(8'h00, 0, 0, 1'b1, 4'b0000);
        check("post_rst_lock", flag(4), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
